// File: rtl/sprite_port_mailbox.sv
// HW/SW mailbox for sprite words. A captured word set is double-buffered and
// committed to the frame displayer atomically on a frame boundary.
module sprite_port_mailbox #(
    parameter int NUM_PORTS   = 16,
    parameter int PORT_WIDTH  = 32,
    parameter int STALE_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS*PORT_WIDTH-1:0] to_hw_port,
    input  logic [1:0]                      to_hw_sig,
    input  logic                            frame_start,
    output logic [1:0]                      to_sw_sig,
    output logic [NUM_PORTS*PORT_WIDTH-1:0] port_out,
    output logic                            commit_pulse,
    output logic [STALE_WIDTH-1:0]          stale_frames
);
    localparam int BANK_WIDTH = NUM_PORTS * PORT_WIDTH;

    localparam logic [1:0] CMD_IDLE     = 2'b00;
    localparam logic [1:0] CMD_REQUEST  = 2'b01;
    localparam logic [1:0] CMD_RESERVED = 2'b10;
    localparam logic [1:0] CMD_ABORT    = 2'b11;

    localparam logic [1:0] STS_IDLE      = 2'b00;
    localparam logic [1:0] STS_CAPTURED  = 2'b01;
    localparam logic [1:0] STS_COMMITTED = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PENDING,
        ST_DONE
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic                    capture;
    logic                    commit;
    logic [1:0]              next_sw_sig;
    logic [BANK_WIDTH-1:0]   shadow;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        next_state = state;
        capture    = 1'b0;
        commit     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (to_hw_sig == CMD_REQUEST) begin
                    capture    = 1'b1;
                    next_state = ST_PENDING;
                end
            end
            ST_PENDING: begin
                // Abort beats a coincident frame_start; the reserved code freezes the handshake.
                if (to_hw_sig == CMD_ABORT) begin
                    next_state = ST_IDLE;
                end else if (frame_start && (to_hw_sig != CMD_RESERVED)) begin
                    commit     = 1'b1;
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if ((to_hw_sig == CMD_IDLE) || (to_hw_sig == CMD_ABORT)) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        next_sw_sig = STS_IDLE;
        case (next_state)
            ST_PENDING: next_sw_sig = STS_CAPTURED;
            ST_DONE:    next_sw_sig = STS_COMMITTED;
            default:    next_sw_sig = STS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state        <= ST_IDLE;
            to_sw_sig    <= STS_IDLE;
            commit_pulse <= 1'b0;
            stale_frames <= '0;
            // NOTE: both banks are cleared because the displayer must see zeros out of reset.
            shadow       <= '0;
            port_out     <= '0;
        end else begin
            state        <= next_state;
            to_sw_sig    <= next_sw_sig;
            commit_pulse <= commit;
            if (capture) begin
                shadow <= to_hw_port;
            end
            if (commit) begin
                port_out <= shadow;
            end
            if (commit) begin
                stale_frames <= '0;
            end else if (frame_start && !(&stale_frames)) begin
                stale_frames <= stale_frames + STALE_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_sprite_port_mailbox.sv
// Scoreboard bench for sprite_port_mailbox: a 16x32 and a 4x20 instance driven in lockstep
// against a behavioural mailbox model.
module tb_sprite_port_mailbox;
    localparam int NP   = 16;
    localparam int PW   = 32;
    localparam int SW   = 8;
    localparam int NP_S = 4;
    localparam int PW_S = 20;
    localparam int STALE_MAX = (1 << SW) - 1;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [1:0]             to_hw_sig;
    logic                   frame_start;
    logic [NP*PW-1:0]       to_hw_port;
    logic [NP_S*PW_S-1:0]   to_hw_port_s;

    logic [1:0]             to_sw_sig,    to_sw_sig_s;
    logic [NP*PW-1:0]       port_out;
    logic [NP_S*PW_S-1:0]   port_out_s;
    logic                   commit_pulse, commit_pulse_s;
    logic [SW-1:0]          stale_frames, stale_frames_s;

    always #5 clk = ~clk;

    sprite_port_mailbox #(.NUM_PORTS(NP), .PORT_WIDTH(PW), .STALE_WIDTH(SW)) u_dut (
        .clk(clk), .reset(reset), .to_hw_port(to_hw_port), .to_hw_sig(to_hw_sig),
        .frame_start(frame_start), .to_sw_sig(to_sw_sig), .port_out(port_out),
        .commit_pulse(commit_pulse), .stale_frames(stale_frames)
    );

    sprite_port_mailbox #(.NUM_PORTS(NP_S), .PORT_WIDTH(PW_S), .STALE_WIDTH(SW)) u_dut_s (
        .clk(clk), .reset(reset), .to_hw_port(to_hw_port_s), .to_hw_sig(to_hw_sig),
        .frame_start(frame_start), .to_sw_sig(to_sw_sig_s), .port_out(port_out_s),
        .commit_pulse(commit_pulse_s), .stale_frames(stale_frames_s)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: which phase the handshake is in, the captured words and the shown words.
    typedef enum int { M_IDLE, M_HELD, M_SHOWN } mode_t;
    mode_t       m_mode;
    logic [31:0] m_shadow [NP];
    logic [31:0] m_active [NP];
    int          m_stale;
    logic [31:0] words [NP];

    typedef struct {
        logic [1:0]           sw;
        logic                 pulse;
        logic [SW-1:0]        stale;
        logic [NP*PW-1:0]     port;
        logic [NP_S*PW_S-1:0] port_s;
    } expect_t;
    expect_t exp_q[$];

    task automatic drive(input logic r, input logic [1:0] sig, input logic fs);
        expect_t e;
        bit      commit;
        commit = 0;
        @(negedge clk);
        reset       = r;
        to_hw_sig   = sig;
        frame_start = fs;
        for (int k = 0; k < NP; k++) to_hw_port[k*PW +: PW] = words[k];
        for (int k = 0; k < NP_S; k++) to_hw_port_s[k*PW_S +: PW_S] = words[k][PW_S-1:0];

        if (r) begin
            m_mode  = M_IDLE;
            m_stale = 0;
            for (int k = 0; k < NP; k++) begin
                m_shadow[k] = '0;
                m_active[k] = '0;
            end
        end else begin
            if (m_mode == M_IDLE && sig == 2'b01) begin
                for (int k = 0; k < NP; k++) m_shadow[k] = words[k];
                m_mode = M_HELD;
            end else if (m_mode == M_HELD && sig == 2'b11) begin
                m_mode = M_IDLE;
            end else if (m_mode == M_HELD && fs && sig != 2'b10) begin
                for (int k = 0; k < NP; k++) m_active[k] = m_shadow[k];
                commit = 1;
                m_mode = M_SHOWN;
            end else if (m_mode == M_SHOWN && (sig == 2'b00 || sig == 2'b11)) begin
                m_mode = M_IDLE;
            end
            if (commit) m_stale = 0;
            else if (fs) m_stale = (m_stale >= STALE_MAX) ? STALE_MAX : m_stale + 1;
        end

        e.sw    = (m_mode == M_IDLE) ? 2'b00 : (m_mode == M_HELD) ? 2'b01 : 2'b10;
        e.pulse = commit;
        e.stale = SW'(m_stale);
        for (int k = 0; k < NP; k++) e.port[k*PW +: PW] = m_active[k];
        for (int k = 0; k < NP_S; k++) e.port_s[k*PW_S +: PW_S] = m_active[k][PW_S-1:0];
        exp_q.push_back(e);
    endtask

    // Monitor: consumes one expectation per clock, shortly after the edge it describes.
    initial begin
        expect_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("to_sw_sig",      to_sw_sig,      e.sw);
                check("commit_pulse",   commit_pulse,   e.pulse);
                check("stale_frames",   stale_frames,   e.stale);
                check("port_out",       port_out,       e.port);
                check("to_sw_sig_s",    to_sw_sig_s,    e.sw);
                check("commit_pulse_s", commit_pulse_s, e.pulse);
                check("stale_frames_s", stale_frames_s, e.stale);
                check("port_out_s",     port_out_s,     e.port_s);
            end
        end
    end

    initial begin
        int          r;
        logic [1:0]  sig;
        reset        = 1'b1;
        to_hw_sig    = 2'b00;
        frame_start  = 1'b0;
        to_hw_port   = '0;
        to_hw_port_s = '0;
        m_mode       = M_IDLE;
        m_stale      = 0;
        for (int k = 0; k < NP; k++) begin
            words[k]    = $urandom;
            m_shadow[k] = '0;
            m_active[k] = '0;
        end

        repeat (3) drive(1, 2'b00, 0);
        drive(0, 2'b00, 0);

        // Basic capture / commit / release with boundary word values.
        words[0]  = 32'h0001_2345;
        words[15] = 32'hDEAD_BEEF;
        repeat (4) drive(0, 2'b01, 0);
        drive(0, 2'b01, 1);
        repeat (3) drive(0, 2'b01, 0);
        repeat (2) drive(0, 2'b00, 0);
        @(posedge clk); #3;
        check("committed_port0",  port_out[0 +: PW],      32'h0001_2345);
        check("committed_port15", port_out[15*PW +: PW],  32'hDEAD_BEEF);
        check("committed_s_port0", port_out_s[0 +: PW_S], 20'h12345);

        // Input changes while PENDING must not reach the shadow bank.
        words[1] = 32'h11;
        drive(0, 2'b01, 0);
        words[1] = 32'h22;
        repeat (2) drive(0, 2'b01, 0);
        drive(0, 2'b01, 1);
        drive(0, 2'b00, 0);
        @(posedge clk); #3;
        check("port1_held_value", port_out[PW +: PW], 32'h11);

        // Request coinciding with frame_start captures only; commit on the next frame_start.
        words[2] = $urandom;
        drive(0, 2'b01, 1);
        repeat (2) drive(0, 2'b01, 0);
        drive(0, 2'b01, 1);
        drive(0, 2'b00, 0);

        // Aborts: plain, coincident with frame_start, and in IDLE.
        words[3] = $urandom;
        repeat (2) drive(0, 2'b01, 0);
        drive(0, 2'b11, 0);
        drive(0, 2'b00, 0);
        repeat (2) drive(0, 2'b01, 0);
        drive(0, 2'b11, 1);
        drive(0, 2'b11, 0);
        drive(0, 2'b00, 1);

        // Reserved command in each state.
        drive(0, 2'b10, 1);
        drive(0, 2'b01, 0);
        drive(0, 2'b10, 0);
        drive(0, 2'b01, 1);
        drive(0, 2'b10, 0);
        drive(0, 2'b00, 0);

        // Saturation of the frames-since-commit counter.
        for (int i = 0; i < 300; i++) begin
            drive(0, 2'b00, 1);
            drive(0, 2'b00, 0);
        end
        @(posedge clk); #3;
        check("stale_saturated", stale_frames, STALE_MAX);

        // Reset in the middle of a handshake.
        drive(0, 2'b01, 0);
        drive(1, 2'b01, 1);
        drive(0, 2'b00, 0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) words[$urandom_range(0, NP-1)] = $urandom;
            r   = $urandom_range(0, 9);
            sig = (r < 4) ? 2'b01 : (r < 7) ? 2'b00 : (r < 9) ? 2'b11 : 2'b10;
            drive($urandom_range(0, 99) == 0, sig, $urandom_range(0, 5) == 0);
        end

        repeat (2) drive(0, 2'b00, 0);
        repeat (2) @(posedge clk);
        #3;
        check("scoreboard_drained", 512'(exp_q.size()), 512'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sprite_port_mailbox.md
# sprite_port_mailbox

Parametrised HW/SW mailbox between the NIOS PIO export ports (`to_hw_port*`, `to_hw_sig`, `to_sw_sig`) and the frame displayer. It supersedes the fixed 16-port, 2-bit handshake path with a configurable port count and width. Software posts a full set of sprite words under a request/acknowledge handshake. The block double-buffers that set and commits it to the displayer atomically on the next frame boundary, so no frame shows a half-updated sprite set.

## Interface
Parameters:
- `NUM_PORTS`, 16, number of software-written words per update
- `PORT_WIDTH`, 32, width of each word
- `STALE_WIDTH`, 8, width of the saturating frames-since-commit counter

Ports:
- `clk`  in  1  system clock (Clk, 50 MHz); one clock, shared with the NIOS PIOs
- `reset`  in  1  synchronous, active-high reset
- `to_hw_port`  in  NUM_PORTS*PORT_WIDTH  flattened software words; port k at bits [k*PORT_WIDTH +: PORT_WIDTH]
- `to_hw_sig`  in  2  software command: 00 idle, 01 request, 11 abort, 10 reserved
- `frame_start`  in  1  one-cycle pulse at the start of vertical blank, from the VGA path
- `to_sw_sig`  out  2  handshake status: 00 idle, 01 captured, 10 committed
- `port_out`  out  NUM_PORTS*PORT_WIDTH  active (committed) bank feeding the frame displayer
- `commit_pulse`  out  1  high for exactly one cycle when `port_out` changes
- `stale_frames`  out  STALE_WIDTH  frame_starts since the last commit; saturates at all-ones

## Operation
- Two banks: `shadow` (capture) and `active` (drives `port_out`). Both clear to 0 on reset.
- State machine:
  - IDLE, `to_sw_sig`=00. On `to_hw_sig`==01, load every word of `to_hw_port` into shadow and go to PENDING.
  - PENDING, `to_sw_sig`=01. On `frame_start`, copy shadow into active, assert `commit_pulse`, and go to DONE. On `to_hw_sig`==11, return to IDLE without committing; shadow contents become don't-care.
  - DONE, `to_sw_sig`=10. On `to_hw_sig`==00 or 11, go to IDLE. While `to_hw_sig` stays 01, hold DONE; no re-capture until software returns to 00.
- `to_hw_sig`==10 is reserved: no state change in any state.
- Abort (11) in IDLE is a no-op.
- `stale_frames`:
  - Cleared in the cycle `commit_pulse` is asserted.
  - Otherwise increments on every `frame_start` and saturates at 2^STALE_WIDTH-1.
  - No wrap-around.
- `to_hw_port` is sampled only in the IDLE→PENDING transition cycle. Changes while PENDING or DONE do not affect the shadow bank.

## Timing
- All outputs are registered. Reset values: `to_sw_sig`=00, `port_out`=0, `commit_pulse`=0, `stale_frames`=0, state IDLE.
- Capture latency: request sampled at edge N; shadow loaded and `to_sw_sig`=01 visible after edge N.
- Commit latency: `frame_start` sampled at edge M; `port_out`, `commit_pulse`=1, `to_sw_sig`=10 and `stale_frames`=0 all visible after edge M.
- Commit always occurs at least one frame_start after capture:
  - A request and a `frame_start` in the same IDLE cycle capture only.
  - Commit then happens at the next `frame_start`.
- Abort and `frame_start` in the same PENDING cycle: abort wins, no commit, and `stale_frames` increments.
- `frame_start` while IDLE or DONE updates only `stale_frames`.
- A reset asserted mid-handshake (any state) returns all state and outputs to reset values on the next edge. Software observes `to_sw_sig`=00 and must re-request.
- Throughput: at most one commit per frame.

## Test plan
- Reset, then `to_hw_sig`=01 with port0=0x00012345 and port15=0xDEADBEEF → `to_sw_sig`=01 next cycle. `port_out` stays 0 until `frame_start`; then port0=0x00012345, port15=0xDEADBEEF, one-cycle `commit_pulse`, `to_sw_sig`=10. Return `to_hw_sig` to 00 → `to_sw_sig`=00.
- Change `to_hw_port` while PENDING (port1 0x11→0x22) → committed port1=0x11.
- Request and `frame_start` in the same cycle → no commit that cycle; commit on the second `frame_start`; `stale_frames` 1→0 at commit.
- Abort during PENDING, including a cycle where abort coincides with `frame_start` → `port_out` unchanged, no `commit_pulse`, `to_sw_sig`=00.
- 300 `frame_start` pulses with no commit (STALE_WIDTH=8) → `stale_frames` saturates at 255. Assert reset mid-PENDING → all outputs return to 0 next cycle.
- Re-run the first scenario with NUM_PORTS=4, PORT_WIDTH=20 → correct word slicing and commit behaviour.
